// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes
// and the parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_BREAK        = 8'hF0;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_error);
    modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_edge_sync.sv
// Synchronizes the raw PS/2 clock and data pins and flags falling edges of
// the clock. Also used by the scan-code receive path.
module ps2_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic clk_fe
);
    logic [SYNC_STAGES-1:0] clk_ff;
    logic [SYNC_STAGES-1:0] data_ff;
    logic                   clk_prev;

    // Idle bus level is high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_ff   <= '1;
            data_ff  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[SYNC_STAGES-2:0], ps2_clk_in};
            data_ff  <= {data_ff[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev <= clk_ff[SYNC_STAGES-1];
        end
    end

    assign clk_s  = clk_ff[SYNC_STAGES-1];
    assign data_s = data_ff[SYNC_STAGES-1];
    assign clk_fe = clk_prev & ~clk_s;
endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked
// bits, ACK check, then wait for an idle bus. Lines are driven open-drain.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_t state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    bit_cnt;
    logic [7:0]    data_q;
    logic          par_q;
    logic          ready_q, busy_q, done_q, error_q;
    logic          clk_s, data_s, clk_fe;
    logic          timeout;

    ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fe     (clk_fe)
    );

    assign cnt_inc = (cnt >= CW'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
    assign timeout = (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cnt         <= '0;
            bit_cnt     <= '0;
            data_q      <= '0;
            par_q       <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy_q      <= 1'b0;
                    if (tx.tx_valid && ready_q) begin
                        data_q     <= tx.tx_data;
                        par_q      <= odd_parity(tx.tx_data);
                        ps2_clk_oe <= 1'b1;
                        cnt        <= '0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= INHIBIT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                // Clock alone low for INHIBIT_CYCLES, then one more cycle with the start bit.
                INHIBIT: begin
                    if (cnt == CW'(INHIBIT_CYCLES)) begin
                        ps2_clk_oe <= 1'b0;
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        state      <= RTS;
                    end else begin
                        if (cnt == CW'(INHIBIT_CYCLES - 1))
                            ps2_data_oe <= 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Timeout outranks any edge seen in the same cycle.
                    if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        error_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        case (state)
                            RTS: state <= SEND;
                            SEND: if (clk_fe) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt < 4'd8) begin
                                    ps2_data_oe <= ~data_q[bit_cnt[2:0]];
                                end else if (bit_cnt == 4'd8) begin
                                    ps2_data_oe <= ~par_q;
                                end else begin
                                    ps2_data_oe <= 1'b0;
                                    state       <= ACK;
                                end
                            end
                            ACK: if (clk_fe) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                if (!data_s) begin
                                    state <= WAIT_IDLE;
                                end else begin
                                    error_q <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state   <= IDLE;
                                end
                            end
                            WAIT_IDLE: if (clk_s && data_s) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign tx.tx_ready = ready_q;
    assign tx.busy     = busy_q;
    assign tx.tx_done  = done_q;
    assign tx.tx_error = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of
// the host and compares them with frames built from the byte value.
module tb_ps2_host_tx;
    localparam int INH = 200;
    localparam int TO  = 3000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if tx();
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx         (tx.slave),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int h = 20;

    always @(negedge clk) begin
        if (tx.tx_done) done_cnt++;
        if (tx.tx_error) err_cnt++;
        if (tx.tx_done && tx.tx_error) begin
            errors++;
            $display("FAIL exclusive: done=%b error=%b, need not both", tx.tx_done, tx.tx_error);
        end
    end

    // Expected wire frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_req(input logic [7:0] d);
        tx.tx_data  = d;
        tx.tx_valid = 1'b1;
        @(negedge clk);
        tx.tx_valid = 1'b0;
    endtask

    task automatic wait_rts(output int inh, output int both, output bit ok);
        int t = 0;
        inh = 0; both = 0;
        while (!ps2_clk_oe && t < 1000) begin @(negedge clk); t++; end
        while (ps2_clk_oe && !ps2_data_oe && inh < 20000) begin inh++; @(negedge clk); end
        while (ps2_clk_oe && ps2_data_oe && both < 100) begin both++; @(negedge clk); end
        ok = !ps2_clk_oe && ps2_data_oe;
    endtask

    // Device generates n_fe clock pulses, sampling the data line on rising edges.
    task automatic dev_clock(input int n_fe, input bit ack, output logic [10:0] bits);
        bits = 'x;
        repeat (h) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= n_fe && i <= 11; i++) begin
            if (i == 11) begin
                dev_data = ack ? 1'b0 : 1'b1;
                repeat (h) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (h) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) bits[i] = ps2_data_in;
            repeat (h) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack, output int inh, output int both,
                        output bit ok, output logic [10:0] bits, output int dn, output int en);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int t = 0;
        send_req(d);
        wait_rts(inh, both, ok);
        dev_clock(11, ack, bits);
        while (done_cnt == d0 && err_cnt == e0 && t < 200) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        dn = done_cnt - d0;
        en = err_cnt - e0;
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        repeat (3) @(negedge clk);
        obs = {ps2_clk_oe, ps2_data_oe, tx.tx_ready, tx.busy, tx.tx_done, tx.tx_error};
        checks++;
        if (obs !== 6'b001000) begin
            errors++;
            $display("FAIL reset_state: got %b need 001000", obs);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int inh, both, dn, en; bit ok; logic [10:0] bits;
        xfer(8'hED, 1'b1, inh, both, ok, bits, dn, en);
        checks++; if (inh !== INH) begin errors++; $display("FAIL basic_inhibit: got %0d need %0d", inh, INH); end
        checks++; if (both !== 1 || !ok) begin errors++; $display("FAIL basic_rts: both=%0d ok=%b need 1/1", both, ok); end
        checks++; if (bits !== 11'b1_1_11101101_0) begin errors++; $display("FAIL basic_frame: got %b need %b", bits, 11'b1_1_11101101_0); end
        checks++; if (dn !== 1 || en !== 0) begin errors++; $display("FAIL basic_pulses: done=%0d err=%0d need 1/0", dn, en); end
        checks++; if (tx.tx_ready !== 1'b1 || tx.busy !== 1'b0) begin errors++; $display("FAIL basic_idle: ready=%b busy=%b need 1/0", tx.tx_ready, tx.busy); end
    endtask

    task automatic test_parity;
        int inh, both, dn, en; bit ok; logic [10:0] bits;
        xfer(8'h01, 1'b1, inh, both, ok, bits, dn, en);
        checks++; if (bits !== frame(8'h01) || bits[9] !== 1'b0) begin errors++; $display("FAIL parity_01: got %b need %b", bits, frame(8'h01)); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL parity_01_done: got %0d need 1", dn); end
        xfer(8'h00, 1'b1, inh, both, ok, bits, dn, en);
        checks++; if (bits !== frame(8'h00) || bits[9] !== 1'b1) begin errors++; $display("FAIL parity_00: got %b need %b", bits, frame(8'h00)); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL parity_00_done: got %0d need 1", dn); end
    endtask

    task automatic test_nack;
        int inh, both, t; bit ok; logic [10:0] bits;
        int d0 = done_cnt;
        send_req(8'hF4);
        wait_rts(inh, both, ok);
        dev_clock(10, 1'b0, bits);
        repeat (h) @(negedge clk);
        dev_clk = 1'b0;
        t = 0;
        while (!tx.tx_error && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (tx.tx_error !== 1'b1 || tx.tx_done !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL nack_pulse: err=%b done=%b oe=%b%b need 1 0 00", tx.tx_error, tx.tx_done, ps2_clk_oe, ps2_data_oe);
        end
        @(negedge clk);
        checks++;
        if (tx.tx_error !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL nack_after: err=%b oe=%b%b need 0 00", tx.tx_error, ps2_clk_oe, ps2_data_oe);
        end
        dev_clk = 1'b1;
        repeat (h) @(negedge clk);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL nack_nodone: got %0d done pulses need 0", done_cnt - d0); end
    endtask

    task automatic test_timeout;
        int inh, both, c; bit ok;
        send_req(8'($urandom));
        wait_rts(inh, both, ok);
        c = 0;
        while (!tx.tx_error && c < TO + 100) begin @(negedge clk); c++; end
        checks++; if (c !== TO) begin errors++; $display("FAIL timeout_cycles: got %0d need %0d", c, TO); end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx.tx_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: oe=%b%b err=%b need 00 1", ps2_clk_oe, ps2_data_oe, tx.tx_error);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int inh, both, dn, en, d0, e0; bit ok; logic [10:0] bits;
        send_req(8'hED);
        wait_rts(inh, both, ok);
        dev_clock(4, 1'b1, bits);
        d0 = done_cnt; e0 = err_cnt;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx.tx_ready !== 1'b1 || tx.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: oe=%b%b ready=%b busy=%b need 00 1 0", ps2_clk_oe, ps2_data_oe, tx.tx_ready, tx.busy);
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt !== d0 || err_cnt !== e0) begin errors++; $display("FAIL reset_mid_pulses: done=%0d err=%0d need 0/0", done_cnt - d0, err_cnt - e0); end
        xfer(8'hF4, 1'b1, inh, both, ok, bits, dn, en);
        checks++; if (bits !== frame(8'hF4) || dn !== 1) begin errors++; $display("FAIL reset_mid_resend: got %b done=%0d need %b done=1", bits, dn, frame(8'hF4)); end
    endtask

    task automatic test_back_to_back;
        int inh, both, t; bit ok; logic [10:0] bits;
        tx.tx_data  = 8'hED;
        tx.tx_valid = 1'b1;
        @(negedge clk);
        tx.tx_data = 8'hFF;
        wait_rts(inh, both, ok);
        dev_clock(11, 1'b1, bits);
        checks++; if (bits !== frame(8'hED)) begin errors++; $display("FAIL b2b_first: got %b need %b", bits, frame(8'hED)); end
        t = 0;
        while (!tx.tx_done && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (tx.tx_done !== 1'b1 || tx.tx_ready !== 1'b0 || ps2_clk_oe !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_cycle: done=%b ready=%b clk_oe=%b need 1 0 0", tx.tx_done, tx.tx_ready, ps2_clk_oe);
        end
        @(negedge clk);
        checks++; if (tx.tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL b2b_ready: ready=%b clk_oe=%b need 1 0", tx.tx_ready, ps2_clk_oe); end
        @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b1 || tx.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: clk_oe=%b busy=%b need 1 1", ps2_clk_oe, tx.busy); end
        tx.tx_valid = 1'b0;
        wait_rts(inh, both, ok);
        dev_clock(11, 1'b1, bits);
        t = 0;
        while (!tx.tx_done && t < 100) begin @(negedge clk); t++; end
        checks++; if (bits !== frame(8'hFF) || tx.tx_done !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b done=%b need %b 1", bits, tx.tx_done, frame(8'hFF)); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random;
        int inh, both, dn, en; bit ok, ack; logic [10:0] bits; logic [7:0] d;
        for (int n = 0; n < 4; n++) begin
            d   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            h   = $urandom_range(8, 24);
            xfer(d, ack, inh, both, ok, bits, dn, en);
            checks++; if (bits !== frame(d)) begin errors++; $display("FAIL rand_frame[%0d]: byte %h got %b need %b", n, d, bits, frame(d)); end
            checks++; if (dn !== int'(ack) || en !== int'(!ack)) begin errors++; $display("FAIL rand_result[%0d]: done=%0d err=%0d need %0d/%0d", n, dn, en, ack, !ack); end
        end
        h = 20;
    endtask

    initial begin
        tx.tx_data  = 8'h00;
        tx.tx_valid = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
